// File: rtl/matriz_scan_pkg.sv
// matriz_scan_pkg -- shared types and default constants for the LED matrix
// column scanner.
//   state_t      : scanner FSM states; BLANK only exists when
//                  MATRIZ_SCAN_BLANK_EN is defined
//   DEF_*        : default values for the matriz_scan parameters
//   cnt_w()      : counter width able to hold 0..m-1 (at least 1 bit)
package matriz_scan_pkg;

  localparam int DEF_NUM_COLS     = 5;
  localparam int DEF_NUM_ROWS     = 7;
  localparam int DEF_PRESCALE     = 50000;
  localparam int DEF_BLANK_CYCLES = 8;

`ifdef MATRIZ_SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1} state_t;
`endif

  function automatic int cnt_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/matriz_scan_if.sv
// matriz_scan_if -- frame load / display drive bundle of the matrix scanner.
//   en, load, frame_data           : driven by the master (system side)
//   col, row, col_idx, frame_done  : driven by the slave (scanner)
// Modports: master (system / testbench), slave (matriz_scan).
interface matriz_scan_if import matriz_scan_pkg::*; #(
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int NUM_ROWS = DEF_NUM_ROWS
);
  localparam int IW = $clog2(NUM_COLS);

  logic                         en;
  logic                         load;
  logic [NUM_COLS*NUM_ROWS-1:0] frame_data;
  logic [NUM_COLS-1:0]          col;
  logic [NUM_ROWS-1:0]          row;
  logic [IW-1:0]                col_idx;
  logic                         frame_done;

  modport master (output en, load, frame_data,
                  input  col, row, col_idx, frame_done);
  modport slave  (input  en, load, frame_data,
                  output col, row, col_idx, frame_done);
endinterface

// File: rtl/matriz_scan_prescaler.sv
// scan_prescaler -- modulo-MOD counter with synchronous clear and count
// enable.
//   clk, rstn : clock, async active-low reset
//   clr       : force count to 0 (wins over en)
//   en        : advance count, wrapping MOD-1 -> 0
//   tc        : count is at MOD-1 (not gated by en; the user qualifies it)
module scan_prescaler import matriz_scan_pkg::*; #(
  parameter int MOD = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int            W    = cnt_w(MOD);
  localparam logic [W-1:0]  LAST = W'(MOD - 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tc ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/matriz_scan.sv
// matriz_scan -- multiplexed LED matrix column scanner with double-buffered
// frame memory.
//   clk, rstn : clock, async active-low reset
//   bus       : matriz_scan_if.slave
//     en         scan enable; low -> dark and idle
//     load       one-cycle strobe capturing frame_data into the shadow buffer
//     frame_data bitmap, column c at [c*NUM_ROWS +: NUM_ROWS]
//     col        one-hot column drive (registered)
//     row        row drive of the lit column (registered)
//     col_idx    current column index
//     frame_done one-cycle pulse on the first cycle of each new frame
// Optional feature: define MATRIZ_SCAN_BLANK_EN to insert BLANK_CYCLES dark
// cycles after every column (ghosting suppression). Without it BLANK_CYCLES
// is ignored and columns switch back-to-back.
module matriz_scan import matriz_scan_pkg::*; #(
  parameter int NUM_COLS     = DEF_NUM_COLS,
  parameter int NUM_ROWS     = DEF_NUM_ROWS,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic          clk,
  input  logic          rstn,
  matriz_scan_if.slave  bus
);
  localparam int            IW       = $clog2(NUM_COLS);
  localparam int            FW       = NUM_COLS * NUM_ROWS;
  localparam logic [IW-1:0] LAST_COL = IW'(NUM_COLS - 1);

  state_t              state, nxt_state;
  logic [IW-1:0]       idx, nxt_idx;
  logic [FW-1:0]       active, nxt_active;
  logic [FW-1:0]       shadow, nxt_shadow;
  logic                pend, nxt_pend;
  logic [NUM_COLS-1:0] col_q, nxt_col;
  logic [NUM_ROWS-1:0] row_q, nxt_row;
  logic                done_q;
  logic                adv, wrap, swap;
  logic                pre_tc;

  // Column dwell counter; held at 0 outside SHOW so every column starts fresh.
  scan_prescaler #(.MOD(PRESCALE)) u_pre (
    .clk  (clk),
    .rstn (rstn),
    .clr  (!bus.en || state != SHOW),
    .en   (state == SHOW),
    .tc   (pre_tc)
  );

`ifdef MATRIZ_SCAN_BLANK_EN
  logic blk_tc;

  scan_prescaler #(.MOD(BLANK_CYCLES)) u_blk (
    .clk  (clk),
    .rstn (rstn),
    .clr  (!bus.en || state != BLANK),
    .en   (state == BLANK),
    .tc   (blk_tc)
  );
`endif

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    adv       = 1'b0;
    case (state)
      IDLE: if (bus.en) begin
        nxt_state = SHOW;
        nxt_idx   = '0;
      end
      SHOW: if (pre_tc) begin
`ifdef MATRIZ_SCAN_BLANK_EN
        nxt_state = BLANK;
`else
        adv = 1'b1;
`endif
      end
`ifdef MATRIZ_SCAN_BLANK_EN
      BLANK: if (blk_tc) begin
        nxt_state = SHOW;
        adv       = 1'b1;
      end
`endif
      default: nxt_state = IDLE;
    endcase

    wrap = adv && (idx == LAST_COL);
    if (adv) nxt_idx = wrap ? '0 : idx + 1'b1;

    // Disable overrides everything and suppresses the wrap pulse.
    if (!bus.en) begin
      nxt_state = IDLE;
      nxt_idx   = '0;
      wrap      = 1'b0;
    end

    // Buffer swap only at frame boundaries (or while not scanning) so a
    // frame is never torn. A load landing on the swap bypasses the shadow.
    swap       = wrap || (state == IDLE) || !bus.en;
    nxt_shadow = bus.load ? bus.frame_data : shadow;
    nxt_active = active;
    nxt_pend   = pend;
    if (swap) begin
      if (bus.load)  nxt_active = bus.frame_data;
      else if (pend) nxt_active = shadow;
      nxt_pend = 1'b0;
    end else if (bus.load) begin
      nxt_pend = 1'b1;
    end

    // Outputs are registered from next-state values so they line up with
    // the state register.
    nxt_col = '0;
    nxt_row = '0;
    if (nxt_state == SHOW) begin
      nxt_col = NUM_COLS'(1) << nxt_idx;
      nxt_row = nxt_active[nxt_idx*NUM_ROWS +: NUM_ROWS];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      idx    <= '0;
      active <= '0;
      shadow <= '0;
      pend   <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      idx    <= nxt_idx;
      active <= nxt_active;
      shadow <= nxt_shadow;
      pend   <= nxt_pend;
      col_q  <= nxt_col;
      row_q  <= nxt_row;
      done_q <= wrap;
    end
  end

  assign bus.col        = col_q;
  assign bus.row        = row_q;
  assign bus.col_idx    = idx;
  assign bus.frame_done = done_q;
endmodule
